mc14500_fetch: RTL and testbench

- Instruction fetch sequencer for the MC14500B ICU system: program counter, ROM addressing, instruction latch.
- Splits each fetched word into the ICU opcode and an operand field.
- Operand low 3 bits drive the a[2:0] select of the 8-channel input data selector; the remaining operand bits drive chip-select decode for a bank of selectors.
- Consumes the ICU JMP/RTN flags to compute the next program counter.

---
 rtl/mc14500_fetch.sv | 143 ++++++++++++++
 tb/tb_mc14500_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc14500_fetch.sv
// mc14500_fetch: instruction fetch sequencer for an MC14500B ICU system.
// Holds the program counter and addresses the program ROM with it. Latches
// each fetched word as the ICU opcode plus an operand, then steers the next
// pc from the ICU JMP/RTN flags.
// Optional return stack: define MC14500_FETCH_STACK_EN to enable it.
module mc14500_fetch #(
  parameter int ADDR_W  = 8,
  parameter int OPD_W   = 8,
  parameter int STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [OPD_W+3:0]  rom_data,
  output logic [3:0]        instr,
  output logic [2:0]        io_addr,
  output logic [OPD_W-4:0]  io_sel,
  output logic              instr_valid,
  input  logic              jmp,
  input  logic              rtn,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_err
);

  // Reject parameter sets where the operand cannot carry a jump target or
  // the 3-bit selector address.
  if (OPD_W < ADDR_W || OPD_W < 3 || STACK_D < 1) begin : g_bad_params
    $error("mc14500_fetch: need OPD_W >= ADDR_W, OPD_W >= 3, STACK_D >= 1");
  end

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [3:0]        instr_q;
  logic [OPD_W-1:0]  opd_q;
  logic              valid_q;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = opd_q[ADDR_W-1:0];

`ifdef MC14500_FETCH_STACK_EN
  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [ADDR_W-1:0] stk_mem [STACK_D];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_m1;
  logic              stk_err_q;
  logic              stk_full;
  logic              stk_empty;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W-1:0] stk_top;

  assign stk_full  = (sp_q == SP_W'(STACK_D));
  assign stk_empty = (sp_q == '0);
  assign sp_m1     = sp_q - SP_W'(1);
  assign stk_top   = stk_mem[sp_m1[IDX_W-1:0]];
  // jmp has priority, so a simultaneous rtn never pops.
  assign do_push   = (state_q == EXEC) && jmp && !stk_full;
  assign do_pop    = (state_q == EXEC) && !jmp && rtn && !stk_empty;

  // Return-address storage; only the pointer needs a reset.
  always_ff @(posedge clk) begin
    if (do_push) stk_mem[sp_q[IDX_W-1:0]] <= pc_inc;
  end

  // Stack pointer and sticky overflow/underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q      <= '0;
      stk_err_q <= 1'b0;
    end else begin
      if (do_push) sp_q <= sp_q + SP_W'(1);
      else if (do_pop) sp_q <= sp_m1;
      if (state_q == EXEC) begin
        if (jmp && stk_full) stk_err_q <= 1'b1;
        else if (!jmp && rtn && stk_empty) stk_err_q <= 1'b1;
      end
    end
  end

  assign stk_err = stk_err_q;
`else
  assign stk_err = 1'b0;
`endif

  // Next pc at the end of EXEC: jmp beats rtn, otherwise sequential.
  always_comb begin
    pc_d = pc_inc;
    if (jmp) begin
      pc_d = jmp_tgt;
    end else if (rtn) begin
`ifdef MC14500_FETCH_STACK_EN
      pc_d = stk_empty ? pc_inc : stk_top;
`else
      pc_d = '0;
`endif
    end
  end

  // Two-state fetch/execute sequencer with registered outputs. The latched
  // word is left in place through the next FETCH so the selector address
  // stays put while the ICU writes its result back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= 4'h0;
      opd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (run) begin
            instr_q <= rom_data[OPD_W+3:OPD_W];
            opd_q   <= rom_data[OPD_W-1:0];
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          valid_q <= 1'b0;
          pc_q    <= pc_d;
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign io_addr     = opd_q[2:0];
  assign io_sel      = opd_q[OPD_W-1:3];
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_mc14500_fetch.sv
// tb_mc14500_fetch: scoreboard bench for the fetch sequencer. The stimulus
// process keeps a behavioural model (pc as an integer, return stack as a
// queue) and pushes the expected contents of every executed instruction;
// a monitor pops and compares each time instr_valid is seen.
module tb_mc14500_fetch;
  localparam int ADDR_W  = 8;
  localparam int OPD_W   = 8;
  localparam int STACK_D = 4;
  localparam int NPC     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              jmp = 1'b0;
  logic              rtn = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [OPD_W+3:0]  rom_data;
  logic [3:0]        instr;
  logic [2:0]        io_addr;
  logic [OPD_W-4:0]  io_sel;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              stk_err;

  logic [OPD_W+3:0]  rom [NPC];
  assign rom_data = rom[rom_addr];

  mc14500_fetch #(.ADDR_W(ADDR_W), .OPD_W(OPD_W), .STACK_D(STACK_D)) dut (
    .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .io_addr(io_addr), .io_sel(io_sel), .instr_valid(instr_valid),
    .jmp(jmp), .rtn(rtn), .pc(pc), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [3:0]        op;
    logic [OPD_W-1:0]  opd;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Behavioural model state
  int       m_pc;
  bit       m_exec;
  bit       m_err;
  int       m_opd;
  int       m_stk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_exec = 0;
    m_err = 0;
    m_opd = 0;
    m_stk.delete();
  endtask

  // One clock of stimulus; inputs applied just after the rising edge.
  task automatic cycle(input bit r, input bit j, input bit t);
    exp_t e;
    run = r; jmp = j; rtn = t;
    if (!m_exec) begin
      if (r) begin
        e.pc  = ADDR_W'(m_pc);
        e.op  = rom[m_pc][OPD_W+3:OPD_W];
        e.opd = rom[m_pc][OPD_W-1:0];
        e.err = m_err;
        m_opd = int'(rom[m_pc][OPD_W-1:0]);
        exp_q.push_back(e);
        m_exec = 1;
      end
    end else begin
      if (j) begin
`ifdef MC14500_FETCH_STACK_EN
        if (m_stk.size() == STACK_D) m_err = 1;
        else m_stk.push_back((m_pc + 1) % NPC);
`endif
        m_pc = m_opd % NPC;
      end else if (t) begin
`ifdef MC14500_FETCH_STACK_EN
        if (m_stk.size() == 0) begin
          m_pc = (m_pc + 1) % NPC;
          m_err = 1;
        end else begin
          m_pc = m_stk.pop_back();
        end
`else
        m_pc = 0;
`endif
      end else begin
        m_pc = (m_pc + 1) % NPC;
      end
      m_exec = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    run = 0; jmp = 0; rtn = 0;
    rst = 1;
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_io", 32'({io_addr, io_sel}), 32'h0);
    check("rst_valid_err", 32'({instr_valid, stk_err}), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Step sequentially until the model sits in FETCH at the target pc.
  task automatic run_to(input int target);
    int k = 0;
    while ((m_exec || m_pc != target) && k < 600) begin
      cycle(1, 0, 0);
      k++;
    end
    check("run_to_bound", 32'(k < 600), 32'h1);
  endtask

  task automatic exec_one(input bit j, input bit t);
    cycle(1, 0, 0);
    cycle(1'($urandom), j, t);
  endtask

  // Monitor: one comparison per executed instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid === 1'b1) begin
        n_txn++;
        if (exp_q.size() == 0) begin
          check("unexpected_exec", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d pc=%02h instr=%h io_addr=%0d io_sel=%02h err=%0b",
                   n_txn, pc, instr, io_addr, io_sel, stk_err);
          check("exec", 32'({pc, rom_addr, instr, io_addr, io_sel, stk_err}),
                32'({e.pc, e.pc, e.op, e.opd[2:0], e.opd[OPD_W-1:3], e.err}));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPC; i++) rom[i] = {4'h1, 8'(i)};
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Sequential run across the full address space, wrapping 0xFF -> 0x00.
    for (int i = 0; i < 2 * NPC; i++) cycle(1, 0, 0);
    check("wrap_rom_addr", 32'(rom_addr), 32'h0);
    check("wrap_latched", 32'({instr, io_addr, io_sel}), 32'({4'h1, 3'h7, 5'h1F}));

    // Jump from pc=5 to 0x2A; operand split seen during and after EXEC.
    for (int i = 0; i < NPC; i++) rom[i] = 12'($urandom);
    rom[5] = {4'hC, 8'h2A};
    do_reset();
    run_to(5);
    exec_one(1, 0);
    check("jmp_rom_addr", 32'(rom_addr), 32'h2A);
    check("jmp_io_addr", 32'(io_addr), 32'h2);
    check("jmp_io_sel", 32'(io_sel), 32'h05);

    // Stall at pc=7 for three cycles.
    do_reset();
    run_to(7);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'($urandom), 1'($urandom));
      check("stall_addr_valid", 32'({rom_addr, instr_valid}), 32'({8'h07, 1'b0}));
    end
    cycle(1, 0, 0);
    check("stall_resume_valid", 32'({pc, instr_valid}), 32'({8'h07, 1'b1}));
    cycle(1, 0, 0);

    // jmp and rtn together: jmp wins.
    rom[8] = {4'hC, 8'h40};
    run_to(8);
    exec_one(1, 1);
    check("jmp_rtn_pc", 32'(pc), 32'h40);
    exec_one(0, 1);

`ifdef MC14500_FETCH_STACK_EN
    // Call/return.
    rom[3] = {4'hC, 8'h10};
    do_reset();
    run_to(3);
    exec_one(1, 0);
    run_to(8'h12);
    exec_one(0, 1);
    check("stk_ret_pc", 32'({pc, stk_err}), 32'({8'h04, 1'b0}));
    // Five nested jumps overflow a four-deep stack.
    rom[0] = {4'hC, 8'h10}; rom[8'h10] = {4'hC, 8'h20}; rom[8'h20] = {4'hC, 8'h30};
    rom[8'h30] = {4'hC, 8'h40}; rom[8'h40] = {4'hC, 8'h50};
    do_reset();
    for (int i = 0; i < 4; i++) exec_one(1, 0);
    check("stk_4deep_err", 32'(stk_err), 32'h0);
    exec_one(1, 0);
    check("stk_ovf", 32'({pc, stk_err}), 32'({8'h50, 1'b1}));
    // Return on an empty stack.
    do_reset();
    run_to(9);
    exec_one(0, 1);
    check("stk_unf", 32'({pc, stk_err}), 32'({8'h0A, 1'b1}));
`else
    do_reset();
    run_to(8'h33);
    exec_one(0, 1);
    check("rtn_restart", 32'({pc, stk_err}), 32'({8'h00, 1'b0}));
`endif

    // Reset pulsed mid-EXEC with a pending jump.
    rom[8'h21] = {4'hC, 8'h77};
    run_to(8'h21);
    cycle(1, 0, 0);
    jmp = 1;
    @(negedge clk); #1;
    rst = 1;
    #1;
    check("midexec_outs", 32'({pc, instr, io_addr, io_sel, instr_valid, stk_err}), 32'h0);
    model_reset();
    run = 0; jmp = 0;
    @(posedge clk); #1;
    rst = 0;
    check("midexec_rom_addr", 32'(rom_addr), 32'h0);

    // Randomised run/jmp/rtn with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!m_exec && $urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    run = 0;
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
